// File: rtl/lvds_align_pkg.sv
// Shared types and helpers for the LVDS input-delay training controller.
package lvds_align_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_LOAD,
    S_SETTLE,
    S_DWELL,
    S_EVAL,
    S_CENTER,
    S_NEXT_LANE,
    S_DONE
  } align_state_t;

  localparam int ERR_CNT_W = 16;

  // Middle of a run of len sample points starting at tap 'start', floored.
  function automatic logic [31:0] center_tap(input logic [31:0] start,
                                             input logic [31:0] len,
                                             input logic [31:0] step);
    return start + (((len - 32'd1) * step) >> 1);
  endfunction

endpackage

// File: rtl/lvds_align_ctrl_eye_tracker.sv
// Tracks the current and widest error-free run of sample points over one sweep.
module eye_tracker #(
  parameter int TAP_W = 9,
  parameter int LEN_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             valid,
  input  logic             pass,
  input  logic [TAP_W-1:0] tap,
  input  logic             first,
  input  logic             last,
  output logic [TAP_W-1:0] best_start,
  output logic [LEN_W-1:0] best_len
);

  logic [TAP_W-1:0] cur_start;
  logic [LEN_W-1:0] cur_len;
  logic [LEN_W-1:0] base_len;
  logic [LEN_W-1:0] base_best;
  logic [LEN_W-1:0] run_len;
  logic [TAP_W-1:0] run_start;
  logic             commit;

  // A fail closes the run without extending it; the last point closes it either way.
  always_comb begin
    base_len  = first ? '0 : cur_len;
    base_best = first ? '0 : best_len;
    run_len   = pass ? base_len + LEN_W'(1) : base_len;
    run_start = (base_len == '0) ? tap : cur_start;
    commit    = (!pass || last) && (run_len > base_best);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (valid) begin
      cur_len <= pass ? run_len : '0;
      if (pass)
        cur_start <= run_start;
      if (commit) begin
        best_start <= run_start;
        best_len   <= run_len;
      end else if (first) begin
        best_start <= '0;
        best_len   <= '0;
      end
    end
  end

endmodule

// File: rtl/lvds_align_ctrl.sv
// Per-lane IDELAYE3 tap sweep: counts checker errors per tap, centres each lane in its widest clean window.
module lvds_align_ctrl
  import lvds_align_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int TAP_W    = 9,
  parameter int NTAPS    = 512,
  parameter int TAP_STEP = 8,
  parameter int SETTLE   = 16,
  parameter int DWELL    = 1024,
  parameter int MIN_EYE  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   dly_rdy,
  input  logic [LANES-1:0]       err_in,
  output logic [TAP_W-1:0]       tap_value,
  output logic [LANES-1:0]       tap_load,
  output logic                   busy,
  output logic                   done,
  output logic [LANES-1:0]       lane_fail,
  output logic [LANES*TAP_W-1:0] final_tap
);

  localparam int NPTS   = NTAPS / TAP_STEP;
  localparam int LEN_W  = $clog2(NPTS + 1);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int TMR_W  = $clog2(((SETTLE > DWELL) ? SETTLE : DWELL) + 1);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NTAPS - TAP_STEP);
  localparam logic [TAP_W-1:0] STEP     = TAP_W'(TAP_STEP);

  align_state_t      state;
  logic              rdy_q1, rdy_s, rdy_prev, rdy_fall;
  logic [LANE_W-1:0] lane;
  logic [TAP_W-1:0]  tap;
  logic [TMR_W-1:0]  tmr;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic [TAP_W-1:0]  best_start;
  logic [LEN_W-1:0]  best_len;
  logic              eye_ok;
  logic [TAP_W-1:0]  center;

  always_ff @(posedge clk) begin
    if (reset) begin
      rdy_q1   <= 1'b0;
      rdy_s    <= 1'b0;
      rdy_prev <= 1'b0;
    end else begin
      rdy_q1   <= dly_rdy;
      rdy_s    <= rdy_q1;
      rdy_prev <= rdy_s;
    end
  end

  always_comb begin
    rdy_fall = rdy_prev && !rdy_s;
    eye_ok   = best_len >= LEN_W'(MIN_EYE);
    center   = eye_ok ? TAP_W'((TAP_W + 8)'(center_tap(32'(best_start), 32'(best_len),
                                                        32'(TAP_STEP))))
                      : '0;
  end

  eye_tracker #(
    .TAP_W(TAP_W),
    .LEN_W(LEN_W)
  ) u_eye (
    .clk       (clk),
    .reset     (reset),
    .clear     (state == S_WAIT_RDY),
    .valid     (state == S_EVAL),
    .pass      (err_cnt == '0),
    .tap       (tap),
    .first     (tap == '0),
    .last      (tap == LAST_TAP),
    .best_start(best_start),
    .best_len  (best_len)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      lane      <= '0;
      tap       <= '0;
      tmr       <= '0;
      err_cnt   <= '0;
      tap_value <= '0;
      tap_load  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      lane_fail <= '0;
      final_tap <= '0;
    end else begin
      tap_load <= '0;
      // Losing IDELAYCTRL ready invalidates every tap result gathered so far.
      if (state != S_IDLE && state != S_DONE && rdy_fall) begin
        lane      <= '0;
        lane_fail <= '0;
        final_tap <= '0;
        state     <= S_WAIT_RDY;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            lane      <= '0;
            done      <= 1'b0;
            lane_fail <= '0;
            busy      <= 1'b1;
            state     <= S_WAIT_RDY;
          end
          S_WAIT_RDY: if (rdy_s) begin
            tap   <= '0;
            state <= S_LOAD;
          end
          S_LOAD: begin
            tap_value <= tap;
            tap_load  <= LANES'(1) << lane;
            tmr       <= '0;
            state     <= S_SETTLE;
          end
          S_SETTLE: begin
            if (tmr == TMR_W'(SETTLE - 1)) begin
              tmr     <= '0;
              err_cnt <= '0;
              state   <= S_DWELL;
            end else begin
              tmr <= tmr + TMR_W'(1);
            end
          end
          S_DWELL: begin
            if (err_in[lane] && err_cnt != '1)
              err_cnt <= err_cnt + ERR_CNT_W'(1);
            if (tmr == TMR_W'(DWELL - 1))
              state <= S_EVAL;
            else
              tmr <= tmr + TMR_W'(1);
          end
          S_EVAL: begin
            if (tap == LAST_TAP) begin
              state <= S_CENTER;
            end else begin
              tap   <= tap + STEP;
              state <= S_LOAD;
            end
          end
          S_CENTER: begin
            tap_value <= center;
            tap_load  <= LANES'(1) << lane;
            final_tap[lane*TAP_W +: TAP_W] <= center;
            if (!eye_ok)
              lane_fail[lane] <= 1'b1;
            state <= S_NEXT_LANE;
          end
          S_NEXT_LANE: begin
            if (lane == LANE_W'(LANES - 1)) begin
              state <= S_DONE;
            end else begin
              lane  <= lane + LANE_W'(1);
              state <= S_WAIT_RDY;
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
